seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Run-time programmable serial pattern detector with its own control sequencer.
- Pattern, length and overlap mode load through a valid/ready configuration handshake; start/stop commands arm and disarm detection.
- Mealy detect pulse plus a saturating match counter.
- Sits in front of the serial bit-stream path and replaces fixed-pattern detector instances.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: match counter width.
- LEN_W, 4: width of cfg_len; must hold MAX_LEN.
- TIMEOUT, 64: valid-bit count without a match before auto-stop (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept; high only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is received first.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- start  in  1  arm detection.
- stop  in  1  disarm detection.
- data_valid  in  1  data_in qualifier.
- data_in  in  1  serial bit.
- det_pulse  out  1  Mealy match output, combinational.
- match_count  out  CNT_W  saturating match count.
- cnt_sat  out  1  high while match_count is all ones.
- busy  out  1  high in RUN.
- timeout  out  1  one-cycle pulse on auto-stop (optional feature only).

Behaviour:
- Reset (rst low, async) clears all of the following:
  - FSM to IDLE, configured flag, stored pattern/len/overlap, history, fill counter, match_count.
  - cnt_sat, busy, cfg_err, timeout to 0.
  - cfg_ready goes to 1 at reset release.
- States are IDLE and RUN, held in a 1-bit registered state with a separate combinational next-state block.
- IDLE, configuration:
  - cfg_ready = 1. A handshake completes on cfg_valid & cfg_ready.
  - Valid configuration (2 <= cfg_len <= MAX_LEN): pattern/len/overlap are registered and the configured flag is set.
  - Invalid configuration: cfg_err pulses for the next cycle and the old configuration is kept.
- IDLE, start:
  - start with the configured flag set moves to RUN next cycle.
  - Entering RUN clears the history and fill counter and leaves match_count unchanged.
  - start with no valid configuration is ignored.
  - cfg handshake and start in the same cycle: the configuration is taken and start is ignored.
- RUN, data path:
  - cfg_ready = 0 and busy = 1.
  - On data_valid, history shifts left with data_in entering at the LSB; the fill counter increments, saturating at MAX_LEN.
  - Bits without data_valid are ignored. All data is ignored in IDLE.
- det_pulse (Mealy, same cycle as the completing bit):
  - Asserts when state is RUN, data_valid = 1, fill >= len-1, and {history[len-2:0], data_in} == pattern[len-1:0].
  - Otherwise det_pulse = 0.
- On det_pulse:
  - match_count increments at the clock edge and holds at 2^CNT_W-1.
  - cnt_sat is registered and follows match_count == all ones.
  - Non-overlap mode: the fill counter and history clear, so the next match needs len fresh bits.
  - Overlap mode: history is retained.
- RUN, stop: stop moves to IDLE next cycle. A det_pulse in that same cycle still counts. start together with stop: stop wins.
- match_count clears only on reset. A new configuration does not clear it.
- Reset mid-RUN returns to IDLE immediately, drops det_pulse, and requires reconfiguration.

Optional Feature:
- Macro SEQ_DET_TIMEOUT_EN.
- Defined:
  - A timeout counter counts data_valid bits in RUN and clears on det_pulse and on RUN entry.
  - When it reaches TIMEOUT, the FSM returns to IDLE and timeout pulses for one cycle.
  - The terminating bit may not also be a match. If it is a match, the match counts and the counter clears.
- Undefined: no counter, timeout tied 0, RUN persists until stop or reset.

Test Plan:
- Config 110, len 3, overlap=1; start; stream 1,1,0,1,1,0,1 -> det_pulse on bits 3 and 6; match_count=2.
- Pattern 1111, len 4; stream 1×6 -> overlap=1 gives det on bits 4,5,6 (count 3); overlap=0 gives det on bit 4 only (count 1).
- cfg_len=1 and cfg_len=9 -> cfg_err pulses once each, old pattern still detects; start with no valid config after reset -> busy stays 0.
- CNT_W=4, pattern 10 repeated 20 times -> match_count stops at 15 with cnt_sat=1; det_pulse still pulses.
- Gaps with data_valid=0 inside 110 -> still detected. stop asserted on the completing bit -> counted, then IDLE. rst low mid-stream -> busy, count, config cleared asynchronously.
- With SEQ_DET_TIMEOUT_EN, TIMEOUT=8, pattern 110, stream of 0s -> timeout pulses after the 8th valid bit, busy=0.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable serial pattern detector with IDLE/RUN sequencer.
// Define SEQ_DET_TIMEOUT_EN to auto-stop after TIMEOUT valid bits without a match.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W:0]   FIL_ONE = (LEN_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t r_state;
  state_t w_state_nx;

  logic               r_cfgd;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_err;
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;

  logic               w_idle;
  logic               w_run;
  logic               w_hs;
  logic               w_cfg_ok;
  logic               w_arm;
  logic               w_to_hit;
  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_filled;
  logic               w_match;
  logic               w_det;
  logic [CNT_W-1:0]   w_cnt_nx;

  assign w_idle   = (r_state == S_IDLE);
  assign w_run    = (r_state == S_RUN);
  assign w_hs     = w_idle & cfg_valid;
  assign w_cfg_ok = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
  // A config handshake in the same cycle takes priority over start
  assign w_arm    = w_idle & start & r_cfgd & ~cfg_valid;

  assign w_cand = {r_hist, data_in};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_filled = ({1'b0, r_fill} + FIL_ONE) >= {1'b0, r_len};
  assign w_match  = ((w_cand ^ r_pat) & w_mask) == '0;
  assign w_det    = w_run & data_valid & w_filled & w_match;

  assign w_cnt_nx = (w_det && (r_cnt != CNT_MAX)) ? r_cnt + CNT_ONE : r_cnt;

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] r_to;
  logic            r_tout;

  // The terminating bit only times out when it is not itself a match
  assign w_to_hit = w_run & data_valid & ~w_det & (r_to == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to   <= '0;
      r_tout <= 1'b0;
    end else begin
      r_tout <= w_to_hit;
      if (w_arm || w_to_hit) begin
        r_to <= '0;
      end else if (w_run && data_valid) begin
        r_to <= w_det ? '0 : r_to + TO_ONE;
      end
    end
  end

  assign timeout = r_tout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_arm) w_state_nx = S_RUN;
      S_RUN:  if (stop || w_to_hit) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfgd <= 1'b0;
      r_pat  <= '0;
      r_len  <= '0;
      r_ovl  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_hs & ~w_cfg_ok;
      if (w_hs && w_cfg_ok) begin
        r_cfgd <= 1'b1;
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_ovl  <= cfg_overlap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_arm) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_run && data_valid) begin
      if (w_det && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_cand[MAX_LEN-2:0];
        if (r_fill != LEN_MAX) r_fill <= r_fill + LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_sat <= (w_cnt_nx == CNT_MAX);
    end
  end

  assign cfg_ready   = w_idle;
  assign busy        = w_run;
  assign cfg_err     = r_err;
  assign det_pulse   = w_det;
  assign match_count = r_cnt;
  assign cnt_sat     = r_sat;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed and randomized checks of seq_det_ctrl
// against a queue-based reference model of the detector rules.
module tb_seq_det_ctrl;

  localparam int ML = 8;
  localparam int CW = 4;
  localparam int LW = 4;
  localparam int TO = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          cfg_err;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          data_valid = 1'b0;
  logic          data_in = 1'b0;
  logic          det_pulse;
  logic [CW-1:0] match_count;
  logic          cnt_sat;
  logic          busy;
  logic          timeout;

  seq_det_ctrl #(
    .MAX_LEN(ML), .CNT_W(CW), .LEN_W(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .start(start), .stop(stop),
    .data_valid(data_valid), .data_in(data_in),
    .det_pulse(det_pulse), .match_count(match_count),
    .cnt_sat(cnt_sat), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: bits seen since arming / last non-overlap match
  logic          m_run, m_cfgd, m_ovl, m_err, m_tout;
  logic [ML-1:0] m_pat;
  int            m_len, m_cnt, m_to;
  bit            q[$];
  logic          o_det, e_det;

  function automatic void m_reset();
    m_run = 0; m_cfgd = 0; m_ovl = 0; m_err = 0; m_tout = 0;
    m_pat = '0; m_len = 0; m_cnt = 0; m_to = 0;
    q.delete();
  endfunction

  function automatic logic model_det(logic dv, logic di);
    int v;
    v = 0;
    if (!m_run || !dv || q.size() < m_len - 1) return 1'b0;
    for (int i = q.size() - (m_len - 1); i < q.size(); i++)
      v = (v << 1) | int'(q[i]);
    v = (v << 1) | int'(di);
    return ((v ^ int'(m_pat)) & ((1 << m_len) - 1)) == 0;
  endfunction

  function automatic void model_update(
    logic cv, logic [ML-1:0] cp, logic [LW-1:0] cl, logic co,
    logic st, logic sp, logic dv, logic di, logic det);
    m_err = 0;
    m_tout = 0;
    if (!m_run) begin
      if (cv) begin
        if (cl >= 2 && cl <= ML) begin
          m_pat = cp; m_len = int'(cl); m_ovl = co; m_cfgd = 1;
        end else m_err = 1;
      end else if (st && m_cfgd) begin
        m_run = 1; q.delete(); m_to = 0;
      end
    end else begin
      if (det && m_cnt < CMAX) m_cnt++;
      if (dv) begin
        if (det && !m_ovl) q.delete();
        else begin
          q.push_back(di);
          if (q.size() > ML) void'(q.pop_front());
        end
`ifdef SEQ_DET_TIMEOUT_EN
        if (det) m_to = 0;
        else m_to++;
        if (m_to == TO) begin m_run = 0; m_tout = 1; end
`endif
      end
      if (sp) m_run = 0;
    end
  endfunction

  // One clock: drive at posedge+1, sample det at negedge, update model at posedge
  task automatic step(input logic cv, input logic [ML-1:0] cp,
                      input logic [LW-1:0] cl, input logic co,
                      input logic st, input logic sp,
                      input logic dv, input logic di);
    cfg_valid = cv; cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
    start = st; stop = sp; data_valid = dv; data_in = di;
    @(negedge clk);
    o_det = det_pulse;
    e_det = model_det(dv, di);
    @(posedge clk);
    model_update(cv, cp, cl, co, st, sp, dv, di, e_det);
    #1;
    cfg_valid = 0; start = 0; stop = 0; data_valid = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    #1;
    m_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    #12;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_run++; if (match_count !== '0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", match_count); end
    n_run++; if (cnt_sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %b exp 0", cnt_sat); end
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", cfg_err); end
    n_run++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b exp 0", timeout); end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_start_unconfigured();
    step(0, '0, '0, 0, 1, 0, 0, 0);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uncfg_start busy got %b exp 0", busy); end
  endtask

  task automatic test_basic_110();
    logic [6:0] bits;
    logic [6:0] exp;
    int base;
    bits = 7'b1101101;
    exp  = 7'b0010010;
    step(1, 8'b110, 4'd3, 1, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0, 0);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    base = m_cnt;
    for (int i = 6; i >= 0; i--) begin
      step(0, '0, '0, 0, 0, 0, 1, bits[i]);
      n_run++; if (o_det !== exp[i]) begin n_fail++; $display("FAIL basic_det bit%0d got %b exp %b", 7 - i, o_det, exp[i]); end
    end
    n_run++; if (match_count !== 4'(base + 2)) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", match_count, base + 2); end
    step(0, '0, '0, 0, 0, 1, 0, 0);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_stop busy got %b exp 0", busy); end
  endtask

  task automatic test_overlap();
    logic [5:0] exp_o;
    logic [5:0] exp_n;
    int base;
    exp_o = 6'b000111;
    exp_n = 6'b000100;
    for (int mode = 1; mode >= 0; mode--) begin
      step(1, 8'b1111, 4'd4, 1'(mode), 0, 0, 0, 0);
      step(0, '0, '0, 0, 1, 0, 0, 0);
      base = m_cnt;
      for (int i = 5; i >= 0; i--) begin
        step(0, '0, '0, 0, 0, 0, 1, 1);
        n_run++;
        if (o_det !== (mode == 1 ? exp_o[i] : exp_n[i])) begin
          n_fail++; $display("FAIL ovl%0d_det bit%0d got %b exp %b", mode, 6 - i, o_det, (mode == 1 ? exp_o[i] : exp_n[i]));
        end
      end
      n_run++;
      if (match_count !== 4'(base + (mode == 1 ? 3 : 1))) begin
        n_fail++; $display("FAIL ovl%0d_count got %0d exp %0d", mode, match_count, base + (mode == 1 ? 3 : 1));
      end
      step(0, '0, '0, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_cfg_err();
    logic [2:0] bits;
    step(1, 8'b110, 4'd3, 1, 0, 0, 0, 0);
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_ok err got %b exp 0", cfg_err); end
    step(1, 8'b1, 4'd1, 0, 0, 0, 0, 0);
    n_run++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_len1 err got %b exp 1", cfg_err); end
    step(0, '0, '0, 0, 0, 0, 0, 0);
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_len1 pulse got %b exp 0", cfg_err); end
    step(1, 8'hff, 4'd9, 0, 1, 0, 0, 0);
    n_run++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_len9 err got %b exp 1", cfg_err); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_with_start busy got %b exp 0", busy); end
    step(0, '0, '0, 0, 1, 0, 0, 0);
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_len9 pulse got %b exp 0", cfg_err); end
    n_run++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready got %b exp 0", cfg_ready); end
    bits = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      step(0, '0, '0, 0, 0, 0, 1, bits[i]);
      n_run++; if (o_det !== (i == 0)) begin n_fail++; $display("FAIL cfg_keep det bit%0d got %b exp %b", 3 - i, o_det, (i == 0)); end
    end
    step(0, '0, '0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_gaps_stop();
    int base;
    step(0, '0, '0, 0, 1, 0, 0, 0);
    base = m_cnt;
    step(0, '0, '0, 0, 0, 0, 1, 1);
    step(0, '0, '0, 0, 0, 0, 0, 0);
    step(0, '0, '0, 0, 0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 0, 1, 1);
    step(0, '0, '0, 0, 0, 0, 0, 1);
    n_run++; if (o_det !== 1'b0) begin n_fail++; $display("FAIL gap_det got %b exp 0", o_det); end
    step(0, '0, '0, 0, 1, 1, 1, 0);
    n_run++; if (o_det !== 1'b1) begin n_fail++; $display("FAIL stop_det got %b exp 1", o_det); end
    n_run++; if (match_count !== 4'(base + 1)) begin n_fail++; $display("FAIL stop_count got %0d exp %0d", match_count, base + 1); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b exp 0", busy); end
  endtask

  task automatic test_midrun_reset();
    step(1, 8'b110, 4'd3, 1, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0, 0);
    step(0, '0, '0, 0, 0, 0, 1, 1);
    step(0, '0, '0, 0, 0, 0, 1, 1);
    step(0, '0, '0, 0, 0, 0, 1, 0);
    step(0, '0, '0, 0, 0, 0, 1, 1);
    step(0, '0, '0, 0, 0, 0, 1, 1);
    data_valid = 1; data_in = 0;
    #1;
    n_run++; if (det_pulse !== 1'b1) begin n_fail++; $display("FAIL pre_rst det got %b exp 1", det_pulse); end
    #1;
    rst = 0;
    #1;
    n_run++; if (det_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_rst det got %b exp 0", det_pulse); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst busy got %b exp 0", busy); end
    n_run++; if (match_count !== '0) begin n_fail++; $display("FAIL mid_rst count got %0d exp 0", match_count); end
    m_reset();
    data_valid = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    step(0, '0, '0, 0, 1, 0, 0, 0);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_needs_cfg busy got %b exp 0", busy); end
  endtask

  task automatic test_saturation();
    int k;
    step(1, 8'b10, 4'd2, 0, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0, 0);
    for (k = 1; k <= 20; k++) begin
      step(0, '0, '0, 0, 0, 0, 1, 1);
      step(0, '0, '0, 0, 0, 0, 1, 0);
      n_run++; if (o_det !== 1'b1) begin n_fail++; $display("FAIL sat_det rep%0d got %b exp 1", k, o_det); end
      n_run++; if (match_count !== 4'(k > CMAX ? CMAX : k)) begin n_fail++; $display("FAIL sat_count rep%0d got %0d exp %0d", k, match_count, (k > CMAX ? CMAX : k)); end
      n_run++; if (cnt_sat !== (k >= CMAX)) begin n_fail++; $display("FAIL sat_flag rep%0d got %b exp %b", k, cnt_sat, (k >= CMAX)); end
    end
    step(0, '0, '0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    apply_reset();
    step(1, 8'b110, 4'd3, 1, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0, 0);
`ifdef SEQ_DET_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      step(0, '0, '0, 0, 0, 0, 1, 0);
      n_run++; if (timeout !== (i == TO)) begin n_fail++; $display("FAIL to_pulse bit%0d got %b exp %b", i, timeout, (i == TO)); end
      n_run++; if (busy !== (i != TO)) begin n_fail++; $display("FAIL to_busy bit%0d got %b exp %b", i, busy, (i != TO)); end
    end
    step(0, '0, '0, 0, 0, 0, 1, 0);
    n_run++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle got %b exp 0", timeout); end
`else
    for (int i = 1; i <= 3 * TO; i++) begin
      step(0, '0, '0, 0, 0, 0, 1, 0);
      n_run++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL no_to bit%0d timeout %b busy %b exp 0 1", i, timeout, busy); end
    end
    step(0, '0, '0, 0, 0, 1, 0, 0);
`endif
  endtask

  task automatic test_random();
    logic cv, co, st, sp, dv, di;
    logic [LW-1:0] cl;
    logic [ML-1:0] cp;
    apply_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k % 150 == 149) apply_reset();
      cv = m_run ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 5) == 0);
      cl = ($urandom_range(0, 4) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(2, 4));
      cp = ML'($urandom);
      co = 1'($urandom);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 39) == 0);
      dv = ($urandom_range(0, 3) != 0);
      di = 1'($urandom);
      step(cv, cp, cl, co, st, sp, dv, di);
      n_run++; if (o_det !== e_det) begin n_fail++; $display("FAIL rnd_det cyc%0d got %b exp %b", k, o_det, e_det); end
      n_run++; if (match_count !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_count cyc%0d got %0d exp %0d", k, match_count, m_cnt); end
      n_run++; if (cnt_sat !== (m_cnt == CMAX)) begin n_fail++; $display("FAIL rnd_sat cyc%0d got %b exp %b", k, cnt_sat, (m_cnt == CMAX)); end
      n_run++; if (busy !== m_run) begin n_fail++; $display("FAIL rnd_busy cyc%0d got %b exp %b", k, busy, m_run); end
      n_run++; if (cfg_ready !== !m_run) begin n_fail++; $display("FAIL rnd_ready cyc%0d got %b exp %b", k, cfg_ready, !m_run); end
      n_run++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc%0d got %b exp %b", k, cfg_err, m_err); end
      n_run++; if (timeout !== m_tout) begin n_fail++; $display("FAIL rnd_timeout cyc%0d got %b exp %b", k, timeout, m_tout); end
    end
  endtask

  initial begin
    test_reset();
    test_start_unconfigured();
    test_basic_110();
    test_overlap();
    test_cfg_err();
    test_gaps_stop();
    test_midrun_reset();
    test_saturation();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
